// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: per-register result countdowns plus a writeback
// slot vector, producing stall/issue/forwarding decisions for the ID instruction.
module hazard_scoreboard #(
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_LAT   = 7,
  parameter int LAT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic              issue_use_rs,
  input  logic              issue_use_rt,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              flush,
  output logic              stall,
  output logic              issue_ack,
  output logic              fwd_rs,
  output logic              fwd_rt,
  output logic              busy
);

  logic [LAT_W-1:0] cnt_q [1:REG_COUNT-1];
  logic [LAT_W-1:0] cnt_d [1:REG_COUNT-1];
  logic [MAX_LAT:1] slot_q, slot_d;

  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] cnt_rs, cnt_rt, cnt_rd;
  logic             any_pending, slot_hit;
  logic             raw_rs, raw_rt, waw, wbc, wr_set;

  always_comb begin
    if (issue_lat == '0)
      lat_eff = LAT_W'(1);
    else if (issue_lat > LAT_W'(MAX_LAT))
      lat_eff = LAT_W'(MAX_LAT);
    else
      lat_eff = issue_lat;
  end

  // Register 0 has no counter, so its lookups fall through to zero.
  always_comb begin
    cnt_rs      = '0;
    cnt_rt      = '0;
    cnt_rd      = '0;
    any_pending = 1'b0;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (issue_rs == ADDR_W'(r)) cnt_rs = cnt_q[r];
      if (issue_rt == ADDR_W'(r)) cnt_rt = cnt_q[r];
      if (issue_rd == ADDR_W'(r)) cnt_rd = cnt_q[r];
      if (cnt_q[r] != '0) any_pending = 1'b1;
    end
  end

  always_comb begin
    slot_hit = 1'b0;
    for (int k = 1; k < MAX_LAT; k++) begin
      if (int'(lat_eff) == k && slot_q[k+1]) slot_hit = 1'b1;
    end
  end

  assign raw_rs = issue_use_rs & (issue_rs != '0) & (cnt_rs > LAT_W'(1));
  assign raw_rt = issue_use_rt & (issue_rt != '0) & (cnt_rt > LAT_W'(1));
  assign waw    = issue_wr & (issue_rd != '0) & (cnt_rd >= lat_eff);
  assign wbc    = issue_wr & (issue_rd != '0) & slot_hit;

  assign stall     = ~rst & issue_valid & ~flush & (raw_rs | raw_rt | waw | wbc);
  assign issue_ack = ~rst & issue_valid & ~flush & ~stall;
  assign fwd_rs    = ~rst & issue_use_rs & (issue_rs != '0) & (cnt_rs == LAT_W'(1));
  assign fwd_rt    = ~rst & issue_use_rt & (issue_rt != '0) & (cnt_rt == LAT_W'(1));
  assign busy      = ~rst & any_pending;
  assign wr_set    = issue_ack & issue_wr & (issue_rd != '0);

  // A new write replaces the countdown of its destination rather than decrementing it.
  always_comb begin
    for (int r = 1; r < REG_COUNT; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (wr_set && issue_rd == ADDR_W'(r)) cnt_d[r] = lat_eff;
    end
    slot_d = '0;
    for (int k = 1; k < MAX_LAT; k++) slot_d[k] = slot_q[k+1];
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (wr_set && int'(lat_eff) == k) slot_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < REG_COUNT; r++) cnt_q[r] <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench for hazard_scoreboard; the reference model tracks
// absolute writeback cycles instead of countdowns.
module tb_hazard_scoreboard;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int MAX_LAT   = 7;
  localparam int LAT_W     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              issueValid;
  logic [ADDR_W-1:0] issueRs, issueRt, issueRd;
  logic              issueUseRs, issueUseRt, issueWr;
  logic [LAT_W-1:0]  issueLat;
  logic              flush;
  logic              stall, issueAck, fwdRs, fwdRt, busy;

  hazard_scoreboard #(
    .REG_COUNT(REG_COUNT), .ADDR_W(ADDR_W), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issueValid),
    .issue_rs(issueRs), .issue_rt(issueRt),
    .issue_use_rs(issueUseRs), .issue_use_rt(issueUseRt),
    .issue_wr(issueWr), .issue_rd(issueRd), .issue_lat(issueLat),
    .flush(flush), .stall(stall), .issue_ack(issueAck),
    .fwd_rs(fwdRs), .fwd_rt(fwdRt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic stall;
    logic ack;
    logic fwdRs;
    logic fwdRt;
    logic busy;
    int   cyc;
  } exp_t;

  exp_t expQ[$];
  int   passCount = 0;
  int   totalCount = 0;

  // Reference state: absolute cycle at which each register's result lands,
  // and the set of cycles at which some writeback lands.
  int   now = 0;
  int   doneAt [REG_COUNT];
  bit   wbAt [int];

  function automatic int cntOf(input int r);
    if (r == 0) return 0;
    return (doneAt[r] > now) ? doneAt[r] - now : 0;
  endfunction

  function automatic bit slotAt(input int k);
    return wbAt.exists(now + k);
  endfunction

  task automatic checkOutput(input string name, input logic got, input logic want, input int cyc);
    totalCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, want);
  endtask

  // Drive one ID cycle, predict its outputs, then advance the model past the edge.
  task automatic applyStimulus(input bit r, input bit v, input int rs, input int rt,
                               input bit urs, input bit urt, input bit wr, input int rd,
                               input int lat, input bit fl);
    exp_t e;
    int   latEff, cRs, cRt, cRd;
    bit   rawRs, rawRt, waw, wbc, anyBusy;
    rst = r; issueValid = v; issueRs = ADDR_W'(rs); issueRt = ADDR_W'(rt);
    issueUseRs = urs; issueUseRt = urt; issueWr = wr; issueRd = ADDR_W'(rd);
    issueLat = LAT_W'(lat); flush = fl;
    latEff = (lat == 0) ? 1 : ((lat > MAX_LAT) ? MAX_LAT : lat);
    cRs = cntOf(rs); cRt = cntOf(rt); cRd = cntOf(rd);
    rawRs = urs && rs != 0 && cRs > 1;
    rawRt = urt && rt != 0 && cRt > 1;
    waw   = wr && rd != 0 && cRd >= latEff;
    wbc   = wr && rd != 0 && latEff < MAX_LAT && slotAt(latEff + 1);
    anyBusy = 1'b0;
    for (int i = 1; i < REG_COUNT; i++) if (cntOf(i) != 0) anyBusy = 1'b1;
    e.cyc   = now;
    e.stall = !r && v && !fl && (rawRs || rawRt || waw || wbc);
    e.ack   = !r && v && !fl && !e.stall;
    e.fwdRs = !r && urs && rs != 0 && cRs == 1;
    e.fwdRt = !r && urt && rt != 0 && cRt == 1;
    e.busy  = !r && anyBusy;
    expQ.push_back(e);
    if (r) begin
      for (int i = 0; i < REG_COUNT; i++) doneAt[i] = 0;
      wbAt.delete();
    end else if (e.ack && wr && rd != 0) begin
      doneAt[rd] = now + 1 + latEff;
      wbAt[now + 1 + latEff] = 1'b1;
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Monitor: the DUT presents a decision every cycle; compare away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("stall", stall, e.stall, e.cyc);
      checkOutput("issue_ack", issueAck, e.ack, e.cyc);
      checkOutput("fwd_rs", fwdRs, e.fwdRs, e.cyc);
      checkOutput("fwd_rt", fwdRt, e.fwdRt, e.cyc);
      checkOutput("busy", busy, e.busy, e.cyc);
    end
  end

  initial begin
    for (int i = 0; i < REG_COUNT; i++) doneAt[i] = 0;
    rst = 1'b1; issueValid = 0; issueRs = '0; issueRt = '0; issueUseRs = 0;
    issueUseRt = 0; issueWr = 0; issueRd = '0; issueLat = '0; flush = 0;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 2, 1, 1, 1, 3, 2, 0);
    idle(2);

    // load-use stall, then forwarded issue
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 8, 2, 0);
    applyStimulus(0, 1, 8, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 8, 0, 1, 0, 0, 0, 1, 0);
    idle(3);
    // ALU forwarding on rt
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 3, 1, 0);
    applyStimulus(0, 1, 0, 3, 0, 1, 0, 0, 1, 0);
    idle(3);
    // writeback conflict and retries
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 4, 5, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 4, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 3, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 3, 0);
    idle(8);
    // WAW on r6
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 6, 7, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0, 0, 1, 6, 2, 0);
    idle(8);
    // register 0 write, lat=0 clamp, flush over a RAW hazard
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 7, 0);
    idle(2);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 11, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 10, 4, 0);
    applyStimulus(0, 1, 10, 0, 1, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 10, 10, 1, 1, 1, 10, 2, 0);
    idle(6);
    // reset while r9 is pending
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 9, 7, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 9, 0, 1, 0, 0, 0, 1, 0);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      bit r, v, urs, urt, wr, fl;
      int rs, rt, rd, lat;
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      urs = $urandom_range(0, 1);
      urt = $urandom_range(0, 1);
      wr  = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, REG_COUNT - 1) : $urandom_range(0, 6);
      rt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, REG_COUNT - 1) : $urandom_range(0, 6);
      rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, REG_COUNT - 1) : $urandom_range(0, 6);
      lat = $urandom_range(0, (1 << LAT_W) - 1);
      applyStimulus(r, v, rs, rt, urs, urt, wr, rd, lat, fl);
    end
    idle(1);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      totalCount++;
      $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
    end
    #1;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, number of architectural registers; register 0 is hard-wired zero.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width, with REG_COUNT <= 2**ADDR_W.
REQ-003 SHALL have parameter MAX_LAT, default 7, maximum result latency in cycles, with MAX_LAT >= 2.
REQ-004 SHALL have parameter LAT_W, default 3, latency field width, with 2**LAT_W > MAX_LAT.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port issue_valid  input  1  an instruction in ID requests issue.
REQ-008 SHALL have ports issue_rs, issue_rt  input  ADDR_W  source register numbers.
REQ-009 SHALL have ports issue_use_rs, issue_use_rt  input  1  the matching source is actually read.
REQ-010 SHALL have port issue_wr  input  1  the instruction writes a register.
REQ-011 SHALL have port issue_rd  input  ADDR_W  destination register number.
REQ-012 SHALL have port issue_lat  input  LAT_W  cycles until the result is on the bypass bus (1 = ALU, 2 = load, up to MAX_LAT for mul/div).
REQ-013 SHALL have port flush  input  1  kills the ID instruction this cycle.
REQ-014 SHALL have port stall  output  1  hold the PC and IF/ID registers and insert a bubble into EX.
REQ-015 SHALL have port issue_ack  output  1  the instruction issues this cycle.
REQ-016 SHALL have ports fwd_rs, fwd_rt  output  1  the source takes the bypass bus instead of the register file.
REQ-017 SHALL have port busy  output  1  at least one write is pending.

Function
REQ-018 SHALL hold a counter cnt[r] of LAT_W bits for each register r from 1 to REG_COUNT-1; cnt[0] is constantly 0.
REQ-019 SHALL hold a writeback slot vector slot[1..MAX_LAT]; slot[k] = 1 means a result completes k cycles from now.
REQ-020 SHALL use lat_eff = issue_lat, except lat_eff = 1 when issue_lat = 0 and lat_eff = MAX_LAT when issue_lat > MAX_LAT.
REQ-021 SHALL compute raw_rs = issue_use_rs & (issue_rs != 0) & (cnt[issue_rs] > 1), and raw_rt the same way from the rt inputs.
REQ-022 SHALL compute waw = issue_wr & (issue_rd != 0) & (cnt[issue_rd] >= lat_eff).
REQ-023 SHALL compute wbc = issue_wr & (issue_rd != 0) & (lat_eff < MAX_LAT) & slot[lat_eff+1].
REQ-024 SHALL drive stall = issue_valid & ~flush & (raw_rs | raw_rt | waw | wbc) combinationally in the same cycle.
REQ-025 SHALL drive issue_ack = issue_valid & ~flush & ~stall.
REQ-026 SHALL drive fwd_rs = issue_use_rs & (issue_rs != 0) & (cnt[issue_rs] == 1), and fwd_rt the same way.
REQ-027 SHALL drive busy = 1 exactly when any cnt[r] != 0.
REQ-028 SHALL, on each clock edge, decrement every nonzero cnt[r] by 1 and leave zero counters at zero.
REQ-029 SHALL, on each clock edge, shift slot so that slot'[k] = slot[k+1] and slot'[MAX_LAT] = 0.
REQ-030 SHALL, on an edge with issue_ack & issue_wr & (issue_rd != 0), set cnt'[issue_rd] = lat_eff and slot'[lat_eff] = 1; the set overrides the decrement of the same register.
REQ-031 SHALL make writes to register 0 change no state and never cause waw or wbc.
REQ-032 SHALL let rs = rt = rd within one instruction evaluate RAW against the old cnt value before the update.
REQ-033 SHALL make flush affect only the current ID instruction, leaving every pending counter and slot untouched.
REQ-034 SHALL keep all outputs purely combinational from state and inputs, with zero latency.

Reset
REQ-035 SHALL, on a clock edge with rst = 1, clear every cnt and slot bit regardless of any issue in that cycle.
REQ-036 SHALL hold stall, issue_ack, fwd_rs, fwd_rt and busy at 0 while rst = 1; outputs evaluate normally from the cleared state on the first cycle after rst falls.

Verification
REQ-037 SHALL verify a load-use stall: issue rd=8 with lat=2, then next cycle rs=8 -> stall=1 for one cycle, then issue_ack=1 and fwd_rs=1.
REQ-038 SHALL verify ALU forwarding: rd=3 with lat=1, then next cycle rt=3 -> stall=0, fwd_rt=1, busy=0 one cycle later.
REQ-039 SHALL verify a writeback conflict: issue rd=4 with lat=5, next cycle rd=5 with lat=4 -> wbc stall=1; a retry with lat=3 issues.
REQ-040 SHALL verify WAW: rd=6 with lat=7, next cycle rd=6 with lat=2 -> stall until cnt[6] < 2, then issue.
REQ-041 SHALL verify the register-0 and flush cases: rd=0 with lat=7 leaves busy=0; flush=1 with a RAW hazard gives stall=0 and issue_ack=0.
REQ-042 SHALL verify reset mid-operation: with cnt[9]=5, assert rst for one cycle -> busy=0 and a following rs=9 gives stall=0, fwd_rs=0.
